// File: rtl/decimal_binary.sv
// Keypad entry of a temperature as whole digits plus an optional .0/.5
// fraction, committed to a binary whole value and a half-degree bit on enter.
module decimal_binary #(
    parameter logic [6:0] MAX_WHOLE = 7'd99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       digit_valid,
    input  logic [3:0] digit_code,
    output logic [7:0] data,
    output logic       decimal,
    output logic       data_valid,
    output logic       error,
    output logic       busy,
    output logic [1:0] digit_count
);

    typedef enum logic [1:0] {
        IDLE,
        INT,
        FRAC,
        DONE
    } state_t;

    state_t     state;
    logic [6:0] acc;
    logic       frac_bit;
    logic       frac_set;

    logic       is_digit;
    logic       is_point;
    logic       is_cancel;
    logic       is_illegal;
    logic       frac_ok;
    logic [6:0] acc_x10;
    logic       reject;
    logic       abort;

    assign is_digit   = (digit_code <= 4'd9);
    assign is_point   = (digit_code == 4'd10);
    assign is_cancel  = (digit_code == 4'd14);
    assign is_illegal = (digit_code >= 4'd11) && (digit_code <= 4'd13);
    assign frac_ok    = (digit_code == 4'd0) || (digit_code == 4'd5);

    // acc*10 + digit without a multiplier; 99 still fits in 7 bits
    assign acc_x10 = {acc[3:0], 3'b000} + {acc[5:0], 1'b0}
                   + {3'b000, digit_code};

    assign busy = (state != IDLE);

    // Mid-entry events that abandon the entry, with or without an error
    always_comb begin
        reject = 1'b0;
        abort  = 1'b0;
        if (digit_valid) begin
            unique case (state)
                INT: begin
                    reject = is_illegal
                           || (is_digit && (digit_count == 2'd2));
                    abort  = is_cancel;
                end
                FRAC: begin
                    reject = is_illegal || is_point
                           || (is_digit && (frac_set || !frac_ok));
                    abort  = is_cancel;
                end
                default: begin
                    reject = 1'b0;
                    abort  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            acc         <= '0;
            frac_bit    <= 1'b0;
            frac_set    <= 1'b0;
            digit_count <= 2'd0;
            data        <= 8'd0;
            decimal     <= 1'b0;
            data_valid  <= 1'b0;
            error       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            error      <= 1'b0;

            if (state == DONE) begin
                if (acc <= MAX_WHOLE) begin
                    data       <= {1'b0, acc};
                    decimal    <= frac_bit;
                    data_valid <= 1'b1;
                end else begin
                    error <= 1'b1;
                end
            end

            if ((state == DONE) || reject || abort) begin
                state       <= IDLE;
                acc         <= '0;
                frac_bit    <= 1'b0;
                frac_set    <= 1'b0;
                digit_count <= 2'd0;
                if (reject) begin
                    error <= 1'b1;
                end
            end else if (digit_valid) begin
                unique case (state)
                    IDLE: begin
                        unique case (1'b1)
                            is_digit: begin
                                acc         <= {3'b000, digit_code};
                                digit_count <= 2'd1;
                                state       <= INT;
                            end
                            is_point: begin
                                acc   <= '0;
                                state <= FRAC;
                            end
                            is_cancel: begin
                                state <= IDLE;
                            end
                            default: begin
                                error <= 1'b1;
                            end
                        endcase
                    end
                    INT: begin
                        unique case (1'b1)
                            is_digit: begin
                                acc         <= acc_x10;
                                digit_count <= 2'd2;
                            end
                            is_point: begin
                                state <= FRAC;
                            end
                            default: begin
                                frac_bit <= 1'b0;
                                state    <= DONE;
                            end
                        endcase
                    end
                    FRAC: begin
                        if (is_digit) begin
                            frac_bit <= (digit_code == 4'd5);
                            frac_set <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/decimal_binary.md
DECIMAL_BINARY -- requirements
Module: decimal_binary

Interface
REQ-001 SHALL have parameter MAX_WHOLE, default 7'd99: largest whole-number value accepted on enter.
REQ-002 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-004 SHALL have port digit_valid, input, 1, strobe: digit_code is sampled on any rising clk edge where it is 1.
REQ-005 SHALL have port digit_code, input, 4: 0-9 = decimal digit, 10 = decimal point, 14 = cancel, 15 = enter; 11-13 are illegal.
REQ-006 SHALL have port data, output, 8: committed whole number in binary; data[7] always 0.
REQ-007 SHALL have port decimal, output, 1: committed half-degree bit; 1 = .5, 0 = .0.
REQ-008 SHALL have port data_valid, output, 1: one-cycle pulse when data/decimal are updated.
REQ-009 SHALL have port error, output, 1: one-cycle pulse when an entry is rejected.
REQ-010 SHALL have port busy, output, 1: 1 while state is not IDLE.
REQ-011 SHALL have port digit_count, output, 2: number of whole digits held in the current entry (0-2).

Function
REQ-012 SHALL implement states IDLE, INT, FRAC, DONE; all outputs registered.
REQ-013 IDLE: digit 0-9 -> acc = digit, digit_count = 1, go to INT; point -> acc = 0, go to FRAC; enter -> error pulse, stay IDLE; cancel -> stay IDLE, no pulse.
REQ-014 INT with digit_count = 1: digit -> acc = acc*10 + digit, computed as (acc<<3)+(acc<<1)+digit in 7 bits; digit_count = 2.
REQ-015 INT with digit_count = 2: further digit -> error pulse, go to IDLE.
REQ-016 INT: point -> go to FRAC; enter -> frac_bit = 0, go to DONE.
REQ-017 FRAC: digit 0 -> frac_bit = 0; digit 5 -> frac_bit = 1; both go to DONE-pending (FRAC_SET flag) and wait for enter; any other digit -> error pulse, go to IDLE.
REQ-018 FRAC: second fraction digit after FRAC_SET -> error pulse, go to IDLE; second point -> error pulse, go to IDLE.
REQ-019 FRAC: enter -> go to DONE; a missing fraction digit is treated as 0.
REQ-020 DONE (exactly one cycle, digit_valid ignored): if acc <= MAX_WHOLE, data = {1'b0, acc}, decimal = frac_bit, data_valid = 1; otherwise error = 1 and data/decimal are held. In both cases go to IDLE.
REQ-021 Latency: enter sampled at edge N -> data/decimal/data_valid change at edge N+1; next digit accepted from edge N+2.
REQ-022 Illegal codes 11-13 in any state except DONE -> error pulse, go to IDLE.
REQ-023 Cancel in INT/FRAC -> go to IDLE with no pulse; acc, frac_bit and digit_count are cleared.
REQ-024 On every return to IDLE, acc, frac_bit, FRAC_SET and digit_count SHALL be cleared; data and decimal SHALL hold their last committed values until the next successful commit.
REQ-025 data_valid and error SHALL never be 1 in the same cycle; each is high for exactly one cycle per event.
REQ-026 busy SHALL equal (state != IDLE); digit_count SHALL be 0 in IDLE, FRAC-from-IDLE and after a clear.

Reset
REQ-027 reset = 0 SHALL immediately force: state IDLE, acc = 0, frac_bit = 0, FRAC_SET = 0, data = 0, decimal = 0, data_valid = 0, error = 0, busy = 0, digit_count = 0.
REQ-028 Reset asserted mid-entry SHALL discard the partial entry; no pulse is emitted on release.
REQ-029 The first digit SHALL be accepted on the first rising clk edge after reset returns to 1.

Verification
REQ-030 Digits 2, 7, point, 5, enter -> data = 8'd27, decimal = 1, data_valid high for 1 cycle, one edge after enter.
REQ-031 Digits 9, 9, enter, then 1, 0, 0 -> first entry commits 8'd99, decimal = 0; the third digit "0" produces an error pulse, state returns to IDLE, data stays 99.
REQ-032 Point, 5, enter from IDLE -> data = 0, decimal = 1; digits 3, point, 7 -> error pulse, outputs unchanged.
REQ-033 MAX_WHOLE = 50; digits 6, 0, enter -> error pulse at DONE, data holds the previous value, data_valid stays 0.
REQ-034 Digits 4, 2, then reset low for 1 cycle, then enter -> no data_valid; error pulses (enter in IDLE); data = 0.
REQ-035 Codes 12, 14 and enter on an empty entry, one at a time -> code 12 gives error; 14 gives no pulse; enter gives error; busy stays 0 throughout.
